hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised successor hazard/forwarding unit for the 5-stage pipeline (F/D/E/M/W). Compares
//  register addresses internally for NUM_SRC operands against NUM_WP write ports per stage.
//  Adds a scoreboard for one multi-cycle execute unit (MUL/DIV) with per-register latency countdown.
//  Generates forward selects plus stall/flush for the pipeline registers.
// PARAMETERS
//  NUM_SRC  4   source operands per instruction (A,B,C,D)
//  NUM_WP   2   register write ports per stage
//  AW       4   register address width (2**AW architectural registers)
//  MC_LAT   4   multi-cycle unit latency in cycles, 2..15
//  PC_REG   15  address never forwarded or scoreboarded (reads PC+8)
// PORTS
//  clk         in   1            rising-edge clock
//  reset       in   1            synchronous, active-high
//  RAD         in   NUM_SRC*AW   decode-stage source addresses
//  SrcValidD   in   NUM_SRC      decode source actually read
//  MultiD      in   1            decode instr needs the multi-cycle unit
//  RAE         in   NUM_SRC*AW   execute-stage source addresses
//  SrcValidE   in   NUM_SRC      execute source actually read
//  WAE/WAM/WAW in   NUM_WP*AW    destination addresses per stage
//  RegWriteE/M/W in NUM_WP       write enable per port per stage
//  MemToRegE   in   NUM_WP       E-stage port k is a load
//  MultiStartE in   1            condition-qualified multi-cycle issue in E
//  MultiWAE    in   AW           its destination
//  PCSrcD/E/M/W in  1            PC write in flight per stage
//  BranchTakenE in  1            branch resolved taken in E
//  ForwardE    out  NUM_SRC*FW   per-operand forward select, FW=$clog2(2*NUM_WP+1)
//  StallF, StallD   out 1        active-high hold of F / D registers
//  FlushD, FlushE   out 1        active-high clear of D / E registers
//  MultiBusy   out  1            multi-cycle unit occupied
// BEHAVIOUR
//  Fixed: one clock; reset synchronous, active-high. All outputs 0 while reset is high.
//  Reset clears pending[], cnt[], busy.
//  Forward sel (combinational, operand i):
//   - 0 = register file; k+1 = M port k; NUM_WP+k+1 = W port k.
//   - Priority: M over W, lower port over higher.
//   - Match requires SrcValidE[i], RegWrite, equal address and address != PC_REG.
//  LDRstall: any valid D source == WAE[k] with RegWriteE[k] & MemToRegE[k] (not PC_REG).
//  Scoreboard (sequential):
//   - pending[r] plus 4-bit cnt[r]. MultiStartE sets pending[MultiWAE] and cnt = MC_LAT.
//   - cnt decrements each cycle; pending clears when cnt reaches 1, the same cycle the result
//     enters W port 0.
//   - Issue and clear on the same register in the same cycle: issue wins.
//  SBstall: any valid D source with pending set.
//  STRstall: MultiD & MultiBusy; at most one multi op outstanding.
//  MultiBusy: 1 from the cycle after MultiStartE until pending clears.
//  Stall/flush equations:
//   - PCWrPending = PCSrcD|PCSrcE|PCSrcM; H = LDRstall|SBstall|STRstall.
//   - StallF = H|PCWrPending; StallD = H; FlushE = H|BranchTakenE.
//   - FlushD = PCWrPending|PCSrcW|BranchTakenE.
//   - Flushes never cancel a scoreboard entry; MultiStartE is pre-qualified.
//  Reset mid-countdown drops the entry; the datapath discards the result.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//   - Adds 16-bit saturating counters ldr_stall_cnt, sb_stall_cnt, str_stall_cnt (extra out
//     ports).
//   - Each counts cycles its stall cause is high; cleared by reset.
//  HAZ_PERF_CNT_EN undefined: counter ports and logic absent; behaviour otherwise identical.
// STRUCTURE
//  Package haz_pkg: FW width function, FWD_RF/FWD_M/FWD_W base constants, PC_REG default.
//  Sub-module hazard_sb_entry: one pending bit plus countdown, generated 2**AW times.
// TESTING
//  1. RAE[A]=3, WAM[0]=3, RegWriteM=01, WAW[1]=3, RegWriteW=10 -> ForwardE[A]=1 (M wins).
//  2. WAE[0]=5 load, RAD[B]=5 valid -> StallF=StallD=FlushE=1 one cycle, then ForwardE[B]=3.
//  3. MultiStartE WA=7 (MC_LAT=4), RAD[A]=7 -> stall 3 cycles, released on cycle 4, MultiBusy
//     falls.
//  4. MultiD while MultiBusy -> StallD=1 until busy clears; a second issue then sets new entry.
//  5. PCSrcD=1 -> StallF=1, FlushD=1; BranchTakenE -> FlushE=FlushD=1; RAE=15 never forwarded.
//  6. reset asserted mid-countdown -> next cycle all outputs 0, pending cleared, no stall.

Source files
------------

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants and helpers for the hazard/forwarding unit and its scoreboard.
// Optional HAZ_PERF_CNT_EN build adds stall-cause performance counters.
package haz_pkg;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_NUM_WP  = 2;
    localparam int DEF_AW      = 4;
    localparam int DEF_MC_LAT  = 4;
    localparam int DEF_PC_REG  = 15;

    // Forward-select encoding: 0 = register file, FWD_M + k = M port k, FWD_W + k = W port k
    localparam int FWD_RF = 0;
    localparam int FWD_M  = 1;
    localparam int FWD_W  = FWD_M + DEF_NUM_WP;

    typedef struct packed {
        logic ldr;
        logic sb;
        logic str;
    } haz_cause_t;

    function automatic int fw_width(input int num_wp);
        return $clog2(2 * num_wp + 1);
    endfunction

    function automatic int fwd_w_base(input int num_wp);
        return FWD_M + num_wp;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
        logic [15:0] res;
        res = val;
        if (en && (val != 16'hFFFF)) begin
            res = val + 16'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side signal bundle of the hazard unit; master = pipeline, slave = hazard unit.
// HAZ_PERF_CNT_EN adds the three stall counter outputs.
interface hazard_scoreboard_unit_if
    import haz_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int NUM_WP  = DEF_NUM_WP,
    parameter int AW      = DEF_AW
);
    localparam int FW = fw_width(NUM_WP);

    logic [NUM_SRC*AW-1:0] RAD;
    logic [NUM_SRC-1:0]    SrcValidD;
    logic                  MultiD;
    logic [NUM_SRC*AW-1:0] RAE;
    logic [NUM_SRC-1:0]    SrcValidE;
    logic [NUM_WP*AW-1:0]  WAE, WAM, WAW;
    logic [NUM_WP-1:0]     RegWriteE, RegWriteM, RegWriteW;
    logic [NUM_WP-1:0]     MemToRegE;
    logic                  MultiStartE;
    logic [AW-1:0]         MultiWAE;
    logic                  PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic                  BranchTakenE;
    logic [NUM_SRC*FW-1:0] ForwardE;
    logic                  StallF, StallD, FlushD, FlushE;
    logic                  MultiBusy;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0]           ldr_stall_cnt, sb_stall_cnt, str_stall_cnt;
`endif

    modport master (
`ifdef HAZ_PERF_CNT_EN
        input  ldr_stall_cnt, sb_stall_cnt, str_stall_cnt,
`endif
        output RAD, SrcValidD, MultiD, RAE, SrcValidE, WAE, WAM, WAW,
        output RegWriteE, RegWriteM, RegWriteW, MemToRegE, MultiStartE, MultiWAE,
        output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        input  ForwardE, StallF, StallD, FlushD, FlushE, MultiBusy
    );

    modport slave (
`ifdef HAZ_PERF_CNT_EN
        output ldr_stall_cnt, sb_stall_cnt, str_stall_cnt,
`endif
        input  RAD, SrcValidD, MultiD, RAE, SrcValidE, WAE, WAM, WAW,
        input  RegWriteE, RegWriteM, RegWriteW, MemToRegE, MultiStartE, MultiWAE,
        input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        output ForwardE, StallF, StallD, FlushD, FlushE, MultiBusy
    );

endinterface

// File: rtl/hazard_scoreboard_unit_sb_entry.sv
// One scoreboard slot: pending bit plus latency countdown for a single architectural register.
module hazard_sb_entry
    import haz_pkg::*;
#(
    parameter int MC_LAT = DEF_MC_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    output logic pending
);
    localparam logic [3:0] LAT = 4'(MC_LAT);

    logic       pending_d, pending_q;
    logic [3:0] cnt_d, cnt_q;

    // Next state: issue reloads the counter; pending drops as the count reaches 1 (result in W)
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (issue) begin
            pending_d = 1'b1;
            cnt_d     = LAT;
        end else if (cnt_q != 4'd0) begin
            cnt_d     = cnt_q - 4'd1;
            pending_d = pending_q & (cnt_q != 4'd2);
        end else begin
            pending_d = 1'b0;
            cnt_d     = 4'd0;
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding unit with a multi-cycle execute scoreboard for the 5-stage pipeline.
// Define HAZ_PERF_CNT_EN to add saturating per-cause stall cycle counters.
module hazard_scoreboard_unit
    import haz_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int NUM_WP  = DEF_NUM_WP,
    parameter int AW      = DEF_AW,
    parameter int MC_LAT  = DEF_MC_LAT,
    parameter int PC_REG  = DEF_PC_REG
) (
    input  logic                     clk,
    input  logic                     reset,
    hazard_scoreboard_unit_if.slave  hz
);
    localparam int            FW   = fw_width(NUM_WP);
    localparam int            NREG = 2 ** AW;
    localparam logic [AW-1:0] PC_A = AW'(PC_REG);

    logic [NREG-1:0]       issue_s, pending_s;
    logic [NUM_SRC*FW-1:0] fwd_s;
    logic                  busy_s, pc_wr_pending_s, h_s;
    haz_cause_t            cause_s;

    for (genvar r = 0; r < NREG; r++) begin : g_sb
        assign issue_s[r] = hz.MultiStartE & (hz.MultiWAE == AW'(r)) & (AW'(r) != PC_A);
        hazard_sb_entry #(.MC_LAT(MC_LAT)) u_entry (
            .clk     (clk),
            .reset   (reset),
            .issue   (issue_s[r]),
            .pending (pending_s[r])
        );
    end

    assign busy_s = |pending_s;

    // Forward select per E operand: first hit in order M0..Mn, then W0..Wn
    always_comb begin
        logic          hit;
        logic [AW-1:0] rae;
        fwd_s = '0;
        hit   = 1'b0;
        rae   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rae = hz.RAE[i*AW +: AW];
            hit = 1'b0;
            for (int k = 0; k < NUM_WP; k++) begin
                if (!hit && hz.SrcValidE[i] && hz.RegWriteM[k] &&
                    (hz.WAM[k*AW +: AW] == rae) && (rae != PC_A)) begin
                    fwd_s[i*FW +: FW] = FW'(FWD_M + k);
                    hit = 1'b1;
                end else begin
                    hit = hit;
                end
            end
            for (int k = 0; k < NUM_WP; k++) begin
                if (!hit && hz.SrcValidE[i] && hz.RegWriteW[k] &&
                    (hz.WAW[k*AW +: AW] == rae) && (rae != PC_A)) begin
                    fwd_s[i*FW +: FW] = FW'(fwd_w_base(NUM_WP) + k);
                    hit = 1'b1;
                end else begin
                    hit = hit;
                end
            end
        end
    end

    // Decode-side stall causes: load-use, scoreboard pending, structural multi-cycle
    always_comb begin
        logic [AW-1:0] rad;
        cause_s     = '0;
        rad         = '0;
        cause_s.str = hz.MultiD & busy_s;
        for (int i = 0; i < NUM_SRC; i++) begin
            rad = hz.RAD[i*AW +: AW];
            if (hz.SrcValidD[i] && (rad != PC_A)) begin
                cause_s.sb = cause_s.sb | pending_s[rad];
                for (int k = 0; k < NUM_WP; k++) begin
                    cause_s.ldr = cause_s.ldr | (hz.RegWriteE[k] & hz.MemToRegE[k] &
                                                 (hz.WAE[k*AW +: AW] == rad));
                end
            end else begin
                cause_s = cause_s;
            end
        end
    end

    assign pc_wr_pending_s = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
    assign h_s             = cause_s.ldr | cause_s.sb | cause_s.str;

    // Output stage; everything is held at zero while reset is high
    always_comb begin
        if (reset) begin
            hz.ForwardE  = '0;
            hz.StallF    = 1'b0;
            hz.StallD    = 1'b0;
            hz.FlushD    = 1'b0;
            hz.FlushE    = 1'b0;
            hz.MultiBusy = 1'b0;
        end else begin
            hz.ForwardE  = fwd_s;
            hz.StallF    = h_s | pc_wr_pending_s;
            hz.StallD    = h_s;
            hz.FlushD    = pc_wr_pending_s | hz.PCSrcW | hz.BranchTakenE;
            hz.FlushE    = h_s | hz.BranchTakenE;
            hz.MultiBusy = busy_s;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] ldr_cnt_d, ldr_cnt_q, sb_cnt_d, sb_cnt_q, str_cnt_d, str_cnt_q;

    // Saturating cycle counts per stall cause
    always_comb begin
        ldr_cnt_d = sat_inc16(ldr_cnt_q, cause_s.ldr);
        sb_cnt_d  = sat_inc16(sb_cnt_q, cause_s.sb);
        str_cnt_d = sat_inc16(str_cnt_q, cause_s.str);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ldr_cnt_q <= 16'd0;
            sb_cnt_q  <= 16'd0;
            str_cnt_q <= 16'd0;
        end else begin
            ldr_cnt_q <= ldr_cnt_d;
            sb_cnt_q  <= sb_cnt_d;
            str_cnt_q <= str_cnt_d;
        end
    end

    assign hz.ldr_stall_cnt = ldr_cnt_q;
    assign hz.sb_stall_cnt  = sb_cnt_q;
    assign hz.str_stall_cnt = str_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit (default parameters, 4-cycle multi unit).
module tb_hazard_scoreboard_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.NUM_SRC(4), .NUM_WP(2), .AW(4)) hz ();

    hazard_scoreboard_unit #(
        .NUM_SRC(4), .NUM_WP(2), .AW(4), .MC_LAT(4), .PC_REG(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ctrl = {StallF, StallD, FlushD, FlushE}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {12'd0, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}, {12'd0, exp});
    endtask

    task automatic chk_fwd(input string tag, input logic [11:0] exp);
        chk(tag, {4'd0, hz.ForwardE}, {4'd0, exp});
    endtask

    task automatic chk_busy(input string tag, input logic exp);
        chk(tag, {15'd0, hz.MultiBusy}, {15'd0, exp});
    endtask

    task automatic clr();
        hz.RAD = '0; hz.SrcValidD = '0; hz.MultiD = 1'b0;
        hz.RAE = '0; hz.SrcValidE = '0;
        hz.WAE = '0; hz.WAM = '0; hz.WAW = '0;
        hz.RegWriteE = '0; hz.RegWriteM = '0; hz.RegWriteW = '0; hz.MemToRegE = '0;
        hz.MultiStartE = 1'b0; hz.MultiWAE = '0;
        hz.PCSrcD = 1'b0; hz.PCSrcE = 1'b0; hz.PCSrcM = 1'b0; hz.PCSrcW = 1'b0;
        hz.BranchTakenE = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        clr();
        reset = 1'b1;
        // outputs stay zero under reset even with active causes
        hz.PCSrcD = 1'b1; hz.BranchTakenE = 1'b1;
        hz.RAE[3:0] = 4'd3; hz.SrcValidE = 4'b0001; hz.WAM[3:0] = 4'd3; hz.RegWriteM = 2'b01;
        sample();
        chk_ctl("reset_ctl", 4'b0000);
        chk_fwd("reset_fwd", 12'h000);
        chk_busy("reset_busy", 1'b0);
        tick(); tick();
        reset = 1'b0;
        clr();

        // 1: M port 0 beats W port 1
        hz.RAE[3:0] = 4'd3; hz.SrcValidE = 4'b0001;
        hz.WAM[3:0] = 4'd3; hz.RegWriteM = 2'b01;
        hz.WAW[7:4] = 4'd3; hz.RegWriteW = 2'b10;
        sample(); chk_fwd("fwd_m_over_w", 12'h001);
        hz.RegWriteM = 2'b00;
        sample(); chk_fwd("fwd_w1", 12'h004);
        hz.SrcValidE = 4'b0000;
        sample(); chk_fwd("fwd_invalid_src", 12'h000);
        hz.SrcValidE = 4'b1001; hz.RAE[15:12] = 4'd3;
        hz.WAM[7:4] = 4'd3; hz.RegWriteM = 2'b10;
        sample(); chk_fwd("fwd_m1_two_ops", 12'h402);
        hz.RegWriteM = 2'b11;
        sample(); chk_fwd("fwd_low_port", 12'h201);
        chk_ctl("fwd_no_stall", 4'b0000);

        // 2: load-use stall, then forward from W port 0
        tick(); clr();
        hz.WAE[3:0] = 4'd5; hz.RegWriteE = 2'b01; hz.MemToRegE = 2'b01;
        hz.RAD[7:4] = 4'd5; hz.SrcValidD = 4'b0010;
        sample(); chk_ctl("ldr_stall", 4'b1101);
        hz.MemToRegE = 2'b00;
        sample(); chk_ctl("alu_no_stall", 4'b0000);
        hz.MemToRegE = 2'b01; hz.SrcValidD = 4'b0000;
        sample(); chk_ctl("ldr_src_invalid", 4'b0000);
        tick(); clr();
        hz.WAW[3:0] = 4'd5; hz.RegWriteW = 2'b01;
        hz.RAE[7:4] = 4'd5; hz.SrcValidE = 4'b0010;
        sample(); chk_fwd("ldr_fwd_w0", 12'h018);

        // 3: multi-cycle issue to r7, dependent decode stalls 3 cycles
        tick(); clr();
        hz.MultiStartE = 1'b1; hz.MultiWAE = 4'd7;
        hz.RAD[3:0] = 4'd7; hz.SrcValidD = 4'b0001;
        sample(); chk_ctl("sb_issue_cycle", 4'b0000); chk_busy("sb_issue_busy", 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            hz.MultiStartE = 1'b0;
            sample();
            chk_ctl($sformatf("sb_cyc%0d", c), (c < 4) ? 4'b1101 : 4'b0000);
            chk_busy($sformatf("sb_busy%0d", c), (c < 4) ? 1'b1 : 1'b0);
        end

        // 4: structural stall while busy, then second issue
        tick(); clr();
        hz.MultiStartE = 1'b1; hz.MultiWAE = 4'd2;
        for (int c = 1; c <= 4; c++) begin
            tick();
            hz.MultiStartE = 1'b0; hz.MultiD = 1'b1;
            sample();
            chk_ctl($sformatf("str_cyc%0d", c), (c < 4) ? 4'b1101 : 4'b0000);
        end
        hz.MultiD = 1'b0; hz.MultiStartE = 1'b1; hz.MultiWAE = 4'd9;
        tick();
        hz.MultiStartE = 1'b0;
        hz.RAD[11:8] = 4'd9; hz.SrcValidD = 4'b0100;
        sample(); chk_busy("second_busy", 1'b1); chk_ctl("second_sb_stall", 4'b1101);
        hz.RAD[11:8] = 4'd2;
        sample(); chk_ctl("old_entry_clear", 4'b0000);

        // 6: reset mid-countdown drops the entry
        tick();
        hz.RAD[11:8] = 4'd9; reset = 1'b1;
        hz.RAE[3:0] = 4'd4; hz.SrcValidE = 4'b0001; hz.WAM[3:0] = 4'd4; hz.RegWriteM = 2'b01;
        sample(); chk_ctl("midrst_ctl", 4'b0000); chk_fwd("midrst_fwd", 12'h000);
        chk_busy("midrst_busy", 1'b0);
        tick();
        reset = 1'b0;
        sample(); chk_ctl("postrst_no_stall", 4'b0000); chk_busy("postrst_busy", 1'b0);
        chk_fwd("postrst_fwd", 12'h001);

        // 5: PC writes, branch, and PC register never forwarded or scoreboarded
        tick(); clr();
        hz.PCSrcD = 1'b1;
        sample(); chk_ctl("pcsrcd", 4'b1010);
        hz.PCSrcD = 1'b0; hz.PCSrcM = 1'b1;
        sample(); chk_ctl("pcsrcm", 4'b1010);
        hz.PCSrcM = 1'b0; hz.PCSrcW = 1'b1;
        sample(); chk_ctl("pcsrcw", 4'b0010);
        hz.PCSrcW = 1'b0; hz.BranchTakenE = 1'b1;
        sample(); chk_ctl("branch", 4'b0011);
        clr();
        hz.RAE[3:0] = 4'd15; hz.SrcValidE = 4'b0001;
        hz.WAM[3:0] = 4'd15; hz.RegWriteM = 2'b01;
        hz.WAW[3:0] = 4'd15; hz.RegWriteW = 2'b01;
        hz.WAE[3:0] = 4'd15; hz.RegWriteE = 2'b01; hz.MemToRegE = 2'b01;
        hz.RAD[3:0] = 4'd15; hz.SrcValidD = 4'b0001;
        hz.MultiStartE = 1'b1; hz.MultiWAE = 4'd15;
        sample(); chk_fwd("pc_no_fwd", 12'h000); chk_ctl("pc_no_ldr", 4'b0000);
        tick();
        hz.MultiStartE = 1'b0;
        sample(); chk_busy("pc_no_sb", 1'b0); chk_ctl("pc_no_sbstall", 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
